// File: rtl/regfile_multiport.sv
`default_nettype none
// ============================================================================
// Module   : regfile_multiport
// Brief    : Parametrised NREAD x NWRITE register file with write priority,
//            optional write->read bypass, optional registered reads and
//            same-cycle write-collision flag.
// Revision : 1.0
// ============================================================================
module regfile_multiport #(
  parameter int               WIDTH        = 4,
  parameter int               DEPTH        = 4,
  parameter int               NREAD        = 2,
  parameter int               NWRITE       = 2,
  parameter bit               BYPASS       = 1'b1,
  parameter int               READ_LATENCY = 0,
  parameter logic [WIDTH-1:0] INIT         = '0,
  localparam int              AW           = $clog2(DEPTH)
) (
  input  logic                    real_clk,
  input  logic                    real_rst,
  input  logic [NWRITE-1:0]       wr_en,
  input  logic [NWRITE*AW-1:0]    wr_addr,
  input  logic [NWRITE*WIDTH-1:0] wr_data,
  input  logic [NREAD*AW-1:0]     rd_addr,
  output logic [NREAD*WIDTH-1:0]  rd_data,
  output logic                    wr_conflict
);

  // One extra bit so the range check is meaningful for power-of-two depths too
  localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

  logic [NWRITE-1:0][AW-1:0]    w_waddr;
  logic [NWRITE-1:0][WIDTH-1:0] w_wdata;
  logic [NREAD-1:0][AW-1:0]     w_raddr;
  logic [NREAD-1:0][WIDTH-1:0]  w_rd_val;
  logic [NWRITE-1:0]            w_wr_act;
  logic                         w_conflict;
  logic                         r_conflict;
  logic [WIDTH-1:0]             r_mem [DEPTH];

  assign w_waddr = wr_addr;
  assign w_wdata = wr_data;
  assign w_raddr = rd_addr;

  for (genvar w = 0; w < NWRITE; w++) begin : g_wr
    assign w_wr_act[w] = wr_en[w] & ({1'b0, w_waddr[w]} < c_depth);
  end

  // Ascending port order: the highest-index port's assignment lands last and wins
  always_ff @(posedge real_clk or posedge real_rst) begin
    if (real_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= INIT;
    end else begin
      for (int w = 0; w < NWRITE; w++) begin
        if (w_wr_act[w]) r_mem[w_waddr[w]] <= w_wdata[w];
      end
    end
  end

  always_comb begin
    w_conflict = 1'b0;
    for (int i = 0; i < NWRITE; i++) begin
      for (int j = i + 1; j < NWRITE; j++) begin
        if (w_wr_act[i] && w_wr_act[j] && (w_waddr[i] == w_waddr[j])) w_conflict = 1'b1;
      end
    end
  end

  always_ff @(posedge real_clk or posedge real_rst) begin
    if (real_rst) r_conflict <= 1'b0;
    else          r_conflict <= w_conflict;
  end

  assign wr_conflict = r_conflict;

  for (genvar r = 0; r < NREAD; r++) begin : g_rd
    logic             w_in_range;
    logic [WIDTH-1:0] w_val;

    assign w_in_range = {1'b0, w_raddr[r]} < c_depth;

    always_comb begin
      w_val = '0;
      if (w_in_range) begin
        w_val = r_mem[w_raddr[r]];
        if (BYPASS) begin
          for (int w = 0; w < NWRITE; w++) begin
            if (w_wr_act[w] && (w_waddr[w] == w_raddr[r])) w_val = w_wdata[w];
          end
        end
      end
    end

    assign w_rd_val[r] = w_val;
  end

  if (READ_LATENCY == 1) begin : g_rd_reg
    logic [NREAD-1:0][WIDTH-1:0] r_rd;

    always_ff @(posedge real_clk or posedge real_rst) begin
      if (real_rst) r_rd <= '0;
      else          r_rd <= w_rd_val;
    end

    assign rd_data = r_rd;
  end else begin : g_rd_comb
    assign rd_data = w_rd_val;
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_multiport.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_multiport
// Brief    : Directed + random checks of regfile_multiport in six configurations
//            against an array-based reference model.
// Revision : 1.0
// ============================================================================
module tb_regfile_multiport;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // default-geometry group (4x4, 2R/2W), four bypass/latency variants share inputs
  logic [1:0] d_en;
  logic [3:0] d_wa;
  logic [7:0] d_wd;
  logic [3:0] d_ra;
  logic [7:0] rd_a, rd_b, rd_c, rd_d;
  logic       cf_a, cf_b, cf_c, cf_d;

  // sweep group (8-bit, depth 6, 3R/3W, INIT 0x55)
  logic [2:0]  s_en;
  logic [8:0]  s_wa;
  logic [23:0] s_wd;
  logic [8:0]  s_ra;
  logic [23:0] rd_s1, rd_s2;
  logic        cf_s1, cf_s2;

  regfile_multiport #(.BYPASS(1'b1), .READ_LATENCY(0)) u_a (
    .real_clk(clk), .real_rst(rst), .wr_en(d_en), .wr_addr(d_wa), .wr_data(d_wd),
    .rd_addr(d_ra), .rd_data(rd_a), .wr_conflict(cf_a));
  regfile_multiport #(.BYPASS(1'b0), .READ_LATENCY(0)) u_b (
    .real_clk(clk), .real_rst(rst), .wr_en(d_en), .wr_addr(d_wa), .wr_data(d_wd),
    .rd_addr(d_ra), .rd_data(rd_b), .wr_conflict(cf_b));
  regfile_multiport #(.BYPASS(1'b1), .READ_LATENCY(1)) u_c (
    .real_clk(clk), .real_rst(rst), .wr_en(d_en), .wr_addr(d_wa), .wr_data(d_wd),
    .rd_addr(d_ra), .rd_data(rd_c), .wr_conflict(cf_c));
  regfile_multiport #(.BYPASS(1'b0), .READ_LATENCY(1)) u_d (
    .real_clk(clk), .real_rst(rst), .wr_en(d_en), .wr_addr(d_wa), .wr_data(d_wd),
    .rd_addr(d_ra), .rd_data(rd_d), .wr_conflict(cf_d));
  regfile_multiport #(.WIDTH(8), .DEPTH(6), .NREAD(3), .NWRITE(3), .BYPASS(1'b1),
                      .READ_LATENCY(0), .INIT(8'h55)) u_s1 (
    .real_clk(clk), .real_rst(rst), .wr_en(s_en), .wr_addr(s_wa), .wr_data(s_wd),
    .rd_addr(s_ra), .rd_data(rd_s1), .wr_conflict(cf_s1));
  regfile_multiport #(.WIDTH(8), .DEPTH(6), .NREAD(3), .NWRITE(3), .BYPASS(1'b0),
                      .READ_LATENCY(1), .INIT(8'h55)) u_s2 (
    .real_clk(clk), .real_rst(rst), .wr_en(s_en), .wr_addr(s_wa), .wr_data(s_wd),
    .rd_addr(s_ra), .rd_data(rd_s2), .wr_conflict(cf_s2));

  int errors = 0;
  int checks = 0;

  // reference state: group 0 = default, group 1 = sweep
  int mem[2][8];
  int reg_b1[2][3];
  int reg_b0[2][3];
  int conf[2];

  task automatic chk(input string tag, input string what, input int idx,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s %s[%0d]: observed=%0h expected=%0h", tag, what, idx, obs, exp);
    end
  endtask

  function automatic int nports(input int g);
    return (g != 0) ? 3 : 2;
  endfunction

  function automatic int depth(input int g);
    return (g != 0) ? 6 : 4;
  endfunction

  function automatic int wen(input int g, input int w);
    if (g != 0) return int'(s_en[w]);
    return int'(d_en[w]);
  endfunction

  function automatic int waddr(input int g, input int w);
    if (g != 0) return int'(s_wa[w*3 +: 3]);
    return int'(d_wa[w*2 +: 2]);
  endfunction

  function automatic int wdata(input int g, input int w);
    if (g != 0) return int'(s_wd[w*8 +: 8]);
    return int'(d_wd[w*4 +: 4]);
  endfunction

  function automatic int raddr(input int g, input int r);
    if (g != 0) return int'(s_ra[r*3 +: 3]);
    return int'(d_ra[r*2 +: 2]);
  endfunction

  // Value a read port should see: out of range -> 0, else highest enabled writer (if bypass), else storage
  function automatic int exp_read(input int g, input int r, input bit byp);
    int a;
    a = raddr(g, r);
    if (a >= depth(g)) return 0;
    if (byp) begin
      for (int w = nports(g) - 1; w >= 0; w--) begin
        if (wen(g, w) != 0 && waddr(g, w) == a) return wdata(g, w);
      end
    end
    return mem[g][a];
  endfunction

  function automatic int collide(input int g);
    int hits[8];
    foreach (hits[i]) hits[i] = 0;
    for (int w = 0; w < nports(g); w++) begin
      if (wen(g, w) != 0 && waddr(g, w) < depth(g)) hits[waddr(g, w)]++;
    end
    foreach (hits[i]) if (hits[i] > 1) return 1;
    return 0;
  endfunction

  task automatic apply_writes(input int g);
    for (int w = 0; w < nports(g); w++) begin
      if (wen(g, w) != 0 && waddr(g, w) < depth(g)) mem[g][waddr(g, w)] = wdata(g, w);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mem[0][i] = 0;
      mem[1][i] = 'h55;
    end
    for (int g = 0; g < 2; g++) begin
      conf[g] = 0;
      for (int r = 0; r < 3; r++) begin
        reg_b1[g][r] = 0;
        reg_b0[g][r] = 0;
      end
    end
  endtask

  // Called just after a falling edge with inputs already driven
  task automatic step(input string tag);
    int nb1[2][3];
    int nb0[2][3];
    int nc[2];
    #1;
    for (int r = 0; r < 2; r++) begin
      chk(tag, "rdA", r, 32'(rd_a[r*4 +: 4]), exp_read(0, r, 1'b1));
      chk(tag, "rdB", r, 32'(rd_b[r*4 +: 4]), exp_read(0, r, 1'b0));
      chk(tag, "rdC", r, 32'(rd_c[r*4 +: 4]), reg_b1[0][r]);
      chk(tag, "rdD", r, 32'(rd_d[r*4 +: 4]), reg_b0[0][r]);
    end
    chk(tag, "cfA", 0, 32'(cf_a), conf[0]);
    chk(tag, "cfB", 0, 32'(cf_b), conf[0]);
    chk(tag, "cfC", 0, 32'(cf_c), conf[0]);
    chk(tag, "cfD", 0, 32'(cf_d), conf[0]);
    for (int r = 0; r < 3; r++) begin
      chk(tag, "rdS1", r, 32'(rd_s1[r*8 +: 8]), exp_read(1, r, 1'b1));
      chk(tag, "rdS2", r, 32'(rd_s2[r*8 +: 8]), reg_b0[1][r]);
    end
    chk(tag, "cfS1", 0, 32'(cf_s1), conf[1]);
    chk(tag, "cfS2", 0, 32'(cf_s2), conf[1]);
    for (int g = 0; g < 2; g++) begin
      for (int r = 0; r < 3; r++) begin
        nb1[g][r] = (r < nports(g)) ? exp_read(g, r, 1'b1) : 0;
        nb0[g][r] = (r < nports(g)) ? exp_read(g, r, 1'b0) : 0;
      end
      nc[g] = collide(g);
    end
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      apply_writes(0);
      apply_writes(1);
      reg_b1 = nb1;
      reg_b0 = nb0;
      conf   = nc;
    end
    @(negedge clk);
  endtask

  task automatic drive_d(input logic [1:0] en, input logic [1:0] wa0, input logic [3:0] wd0,
                         input logic [1:0] wa1, input logic [3:0] wd1,
                         input logic [1:0] ra0, input logic [1:0] ra1);
    d_en = en;
    d_wa = {wa1, wa0};
    d_wd = {wd1, wd0};
    d_ra = {ra1, ra0};
  endtask

  initial begin
    d_en = '0; d_wa = '0; d_wd = '0; d_ra = '0;
    s_en = '0; s_wa = '0; s_wd = '0; s_ra = '0;
    model_reset();
    repeat (2) @(negedge clk);
    step("reset");
    rst = 1'b0;

    drive_d(2'b11, 2'd1, 4'h5, 2'd2, 4'h9, 2'd1, 2'd2); step("basic_wr");
    drive_d(2'b00, 2'd0, 4'h0, 2'd0, 4'h0, 2'd1, 2'd2); step("basic_rd");

    drive_d(2'b11, 2'd3, 4'h1, 2'd3, 4'hE, 2'd3, 2'd3); step("coll_wr");
    drive_d(2'b00, 2'd0, 4'h0, 2'd0, 4'h0, 2'd3, 2'd3); step("coll_rd");
    step("coll_clr");

    drive_d(2'b01, 2'd0, 4'h2, 2'd0, 4'h0, 2'd0, 2'd0); step("byp_pre");
    drive_d(2'b01, 2'd0, 4'h7, 2'd0, 4'h0, 2'd0, 2'd0); step("byp_wr");
    drive_d(2'b00, 2'd0, 4'h0, 2'd0, 4'h0, 2'd0, 2'd0); step("byp_after");

    drive_d(2'b01, 2'd2, 4'hC, 2'd0, 4'h0, 2'd0, 2'd0); step("rl_pre");
    drive_d(2'b00, 2'd0, 4'h0, 2'd0, 4'h0, 2'd0, 2'd2); step("rl_n");
    step("rl_n1");

    // fill everything, then assert reset mid-cycle and check it takes effect without a clock edge
    drive_d(2'b11, 2'd0, 4'hA, 2'd1, 4'hA, 2'd0, 2'd1);
    s_en = 3'b111; s_wa = {3'd2, 3'd1, 3'd0}; s_wd = {3{8'hAA}}; s_ra = {3'd2, 3'd1, 3'd0};
    step("fill0");
    drive_d(2'b11, 2'd2, 4'hA, 2'd3, 4'hA, 2'd2, 2'd3);
    s_wa = {3'd5, 3'd4, 3'd3}; s_ra = {3'd5, 3'd4, 3'd3};
    step("fill1");
    drive_d(2'b00, 2'd0, 4'h0, 2'd0, 4'h0, 2'd1, 2'd3);
    s_en = 3'b000;
    step("fill_chk");
    #2;
    rst = 1'b1;
    model_reset();
    step("rst_async");
    drive_d(2'b11, 2'd1, 4'hF, 2'd3, 4'hF, 2'd0, 2'd2);
    s_en = 3'b111; s_wa = {3'd5, 3'd1, 3'd0}; s_wd = {3{8'hF0}};
    step("rst_hold");
    rst = 1'b0;
    drive_d(2'b00, 2'd0, 4'h0, 2'd0, 4'h0, 2'd1, 2'd3);
    s_en = 3'b000; s_ra = {3'd5, 3'd1, 3'd0};
    step("rst_drop");

    s_en = 3'b011; s_wa = {3'd0, 3'd6, 3'd7}; s_wd = {8'h00, 8'h66, 8'h77}; s_ra = {3'd0, 3'd6, 3'd7};
    step("oor_wr");
    s_en = 3'b000;
    step("oor_rd");

    repeat (10000) begin
      d_en = 2'($urandom); d_wa = 4'($urandom); d_wd = 8'($urandom); d_ra = 4'($urandom);
      s_en = 3'($urandom); s_wa = 9'($urandom); s_wd = 24'($urandom); s_ra = 9'($urandom);
      rst = ($urandom_range(0, 499) == 0);
      if (rst) model_reset();
      step("random");
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
